// File: rtl/croc_pulse_bank.sv
// Multi-channel pulse/PWM generator with a shared prescaler and per-channel
// staging/shadow configuration so reconfiguration only takes effect at period boundaries.
module croc_pulse_bank #(
  parameter int unsigned NumChannels = 8,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned PrescWidth  = 8,
  localparam int unsigned ChWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [PrescWidth-1:0]  presc_i,
  input  logic                   cfg_we_i,
  input  logic [ChWidth-1:0]     cfg_ch_i,
  input  logic [1:0]             cfg_sel_i,
  input  logic [CntWidth-1:0]    cfg_wdata_i,
  input  logic [NumChannels-1:0] start_i,
  input  logic [NumChannels-1:0] stop_i,
  output logic [NumChannels-1:0] pulse_o,
  output logic [NumChannels-1:0] busy_o,
  output logic [NumChannels-1:0] done_o
);

  typedef struct packed {
    logic [CntWidth-1:0] period;
    logic [CntWidth-1:0] high;
    logic [CntWidth-1:0] rep;
    logic                cont;
    logic                inv;
  } chan_cfg_t;

  typedef enum logic {Idle = 1'b0, Run = 1'b1} state_e;

  logic [PrescWidth-1:0] presc_cnt_q;
  logic                  tick;

  // Shared prescaler; a count above a freshly lowered presc_i wraps straight to 0.
  assign tick = (presc_cnt_q == presc_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_q <= '0;
    end else if (presc_cnt_q >= presc_i) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_q + PrescWidth'(1);
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    state_e              state_q, state_d;
    chan_cfg_t           stg_q, stg_d;
    logic [CntWidth-1:0] per_act_q, per_act_d;
    logic [CntWidth-1:0] high_act_q, high_act_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] rem_q, rem_d;
    logic [CntWidth-1:0] per_eff;
    logic                inv_act_q, inv_act_d;
    logic                cont_act_q, cont_act_d;
    logic                pulse_q, pulse_d;
    logic                busy_q;
    logic                done_q, done_d;
    logic                wr, go, boundary, finish;

    assign wr       = cfg_we_i && (cfg_ch_i == ChWidth'(c));
    assign go       = start_i[c] && !stop_i[c];
    assign per_eff  = (per_act_q == '0) ? CntWidth'(1) : per_act_q;
    assign boundary = tick && (cnt_q == per_eff - CntWidth'(1));
    assign finish   = (state_q == Run) && !start_i[c] && !stop_i[c] && boundary
                      && !cont_act_q && (rem_q == CntWidth'(1));

    // Staging register update from the config port
    always_comb begin
      stg_d = stg_q;
      if (wr) begin
        case (cfg_sel_i)
          2'd0:    stg_d.period = cfg_wdata_i;
          2'd1:    stg_d.high   = cfg_wdata_i;
          2'd2:    stg_d.rep    = cfg_wdata_i;
          default: begin
            stg_d.inv  = cfg_wdata_i[0];
            stg_d.cont = cfg_wdata_i[1];
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= Idle;
      else         state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        Idle:    if (go) state_d = Run;
        Run:     if (stop_i[c] || finish) state_d = Idle;
        default: state_d = Idle;
      endcase
    end

    // Datapath and registered-output next values; start covers both launch and restart
    always_comb begin
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      per_act_d  = per_act_q;
      high_act_d = high_act_q;
      inv_act_d  = inv_act_q;
      cont_act_d = cont_act_q;
      pulse_d    = pulse_q;
      done_d     = 1'b0;
      if (state_d == Idle) begin
        pulse_d = stg_d.inv;
        done_d  = finish;
      end else if (start_i[c]) begin
        cnt_d      = '0;
        rem_d      = (stg_q.rep == '0) ? CntWidth'(1) : stg_q.rep;
        per_act_d  = stg_q.period;
        high_act_d = stg_q.high;
        inv_act_d  = stg_q.inv;
        cont_act_d = stg_q.cont;
        pulse_d    = (stg_q.high != '0) ^ stg_q.inv;
      end else if (boundary) begin
        cnt_d      = '0;
        per_act_d  = stg_q.period;
        high_act_d = stg_q.high;
        inv_act_d  = stg_q.inv;
        cont_act_d = stg_q.cont;
        if (!cont_act_q) rem_d = rem_q - CntWidth'(1);
        pulse_d    = (stg_q.high != '0) ^ stg_q.inv;
      end else if (tick) begin
        cnt_d   = cnt_q + CntWidth'(1);
        pulse_d = (cnt_d < high_act_q) ^ inv_act_q;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stg_q      <= '0;
        per_act_q  <= '0;
        high_act_q <= '0;
        inv_act_q  <= 1'b0;
        cont_act_q <= 1'b0;
        cnt_q      <= '0;
        rem_q      <= '0;
        pulse_q    <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        stg_q      <= stg_d;
        per_act_q  <= per_act_d;
        high_act_q <= high_act_d;
        inv_act_q  <= inv_act_d;
        cont_act_q <= cont_act_d;
        cnt_q      <= cnt_d;
        rem_q      <= rem_d;
        pulse_q    <= pulse_d;
        busy_q     <= (state_d == Run);
        done_q     <= done_d;
      end
    end

    assign pulse_o[c] = pulse_q;
    assign busy_o[c]  = busy_q;
    assign done_o[c]  = done_q;
  end

endmodule

// File: tb/tb_croc_pulse_bank.sv
// Directed and randomized checks of croc_pulse_bank against an arithmetic
// model: expected output follows from tick count, period, high time and repeat count.
module tb_croc_pulse_bank;

  localparam int unsigned NCH = 6;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [7:0]      presc;
  logic            cfg_we;
  logic [2:0]      cfg_ch;
  logic [1:0]      cfg_sel;
  logic [15:0]     cfg_wdata;
  logic [NCH-1:0]  start, stop;
  logic [NCH-1:0]  pulse_o, busy_o, done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  croc_pulse_bank #(.NumChannels(NCH), .CntWidth(16), .PrescWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .presc_i(presc), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_sel_i(cfg_sel), .cfg_wdata_i(cfg_wdata), .start_i(start), .stop_i(stop),
    .pulse_o(pulse_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int p);
    rst_ni = 1'b0; presc = 8'(p); cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0;
    cfg_wdata = '0; start = '0; stop = '0;
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    edges = 0;
  endtask

  task automatic cfg_wr(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = 2'(sel); cfg_wdata = 16'(data);
    tick_edge();
    cfg_we = 1'b0;
  endtask

  // Starts ch and follows it for ncyc cycles, then stops it.
  task automatic run_ch(input int ch, input int per, input int hi, input int rep, input bit inv,
                        input bit cont, input int p, input int ncyc, input int restart_at);
    int pe, re, n;
    bit fresh, running;
    logic [NCH-1:0] ep, eb, ed;
    pe = (per == 0) ? 1 : per;
    re = (rep == 0) ? 1 : rep;
    start[ch] = 1'b1;
    tick_edge();
    start = '0;
    n = 0; fresh = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      ep = '0; eb = '0; ed = '0;
      running = cont || (n < re * pe);
      if (running) begin
        eb[ch] = 1'b1;
        ep[ch] = ((n % pe) < hi) ^ inv;
      end else begin
        ep[ch] = inv;
        ed[ch] = fresh;
      end
      check("run_pulse", 32'(pulse_o), 32'(ep));
      check("run_busy", 32'(busy_o), 32'(eb));
      check("run_done", 32'(done_o), 32'(ed));
      if (k == restart_at) start[ch] = 1'b1;
      tick_edge();
      start = '0;
      fresh = 1'b0;
      if (k == restart_at) n = 0;
      else if (running && (((edges - 1) % (p + 1)) == p)) begin
        n++;
        fresh = !cont && (n == re * pe);
      end
    end
    stop[ch] = 1'b1;
    tick_edge();
    stop = '0;
    ep = '0; ep[ch] = inv;
    check("stop_pulse", 32'(pulse_o), 32'(ep));
    check("stop_busy", 32'(busy_o), 32'd0);
    check("stop_done", 32'(done_o), 32'd0);
  endtask

  task automatic trial(input int ch, input int per, input int hi, input int rep, input bit inv,
                       input bit cont, input int p, input int ncyc, input int restart_at);
    do_reset(p);
    cfg_wr(ch, 0, per);
    cfg_wr(ch, 1, hi);
    cfg_wr(ch, 2, rep);
    cfg_wr(ch, 3, {cont, inv});
    run_ch(ch, per, hi, rep, inv, cont, p, ncyc, restart_at);
  endtask

  initial begin
    int ch, per, hi, rep, p, pe, re, ncyc;
    bit inv, cont;

    do_reset(0);
    check("reset_pulse", 32'(pulse_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);

    // one-shot, prescaled continuous, boundary configurations
    trial(0, 4, 1, 3, 1'b0, 1'b0, 0, 16, -1);
    trial(1, 2, 1, 1, 1'b0, 1'b1, 2, 24, -1);
    trial(4, 3, 0, 2, 1'b1, 1'b0, 0, 10, -1);
    trial(5, 4, 10, 2, 1'b0, 1'b0, 0, 12, -1);
    trial(2, 0, 1, 3, 1'b0, 1'b0, 1, 10, -1);
    trial(3, 3, 1, 0, 1'b0, 1'b0, 0, 7, -1);
    trial(0, 5, 2, 2, 1'b0, 1'b0, 0, 16, 3);

    // shadowed high-time update in the middle of a period
    do_reset(0);
    cfg_wr(2, 0, 8); cfg_wr(2, 1, 2); cfg_wr(2, 3, 2);
    start[2] = 1'b1; tick_edge(); start = '0;
    for (int k = 0; k < 24; k++) begin
      check("shadow_pulse", 32'(pulse_o), ((k % 8) < ((k < 8) ? 2 : 6)) ? 32'h4 : 32'h0);
      if (k == 3) begin
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_sel = 2'd1; cfg_wdata = 16'd6;
      end
      tick_edge();
      cfg_we = 1'b0;
    end

    // start and stop together, out-of-range writes, idle invert
    do_reset(0);
    cfg_wr(3, 0, 4); cfg_wr(3, 1, 2);
    start[3] = 1'b1; stop[3] = 1'b1; tick_edge(); start = '0; stop = '0;
    check("startstop_busy", 32'(busy_o), 32'd0);
    check("startstop_pulse", 32'(pulse_o), 32'd0);
    cfg_wr(7, 3, 1);
    cfg_wr(6, 3, 1);
    tick_edge();
    check("oor_pulse", 32'(pulse_o), 32'd0);
    cfg_wr(5, 3, 1);
    check("idle_inv", 32'(pulse_o), 32'h20);

    // asynchronous reset while four inverted channels run
    do_reset(0);
    for (int c = 0; c < 4; c++) begin
      cfg_wr(c, 0, 4); cfg_wr(c, 1, 1); cfg_wr(c, 3, 3);
    end
    check("multi_idle_inv", 32'(pulse_o), 32'h0f);
    start = 6'b001111; tick_edge(); start = '0;
    check("multi_start_pulse", 32'(pulse_o), 32'h00);
    check("multi_busy", 32'(busy_o), 32'h0f);
    tick_edge(); tick_edge();
    check("multi_low_phase", 32'(pulse_o), 32'h0f);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_pulse", 32'(pulse_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1; edges = 0;
    tick_edge();
    check("post_rst_pulse", 32'(pulse_o), 32'd0);
    check("post_rst_busy", 32'(busy_o), 32'd0);

    // randomized configurations
    for (int t = 0; t < 12; t++) begin
      ch   = int'($urandom_range(0, NCH - 1));
      per  = int'($urandom_range(0, 6));
      hi   = int'($urandom_range(0, 8));
      rep  = int'($urandom_range(0, 3));
      p    = int'($urandom_range(0, 3));
      inv  = 1'($urandom_range(0, 1));
      cont = 1'($urandom_range(0, 1));
      pe   = (per == 0) ? 1 : per;
      re   = (rep == 0) ? 1 : rep;
      ncyc = cont ? 30 : re * pe * (p + 1) + 4;
      trial(ch, per, hi, rep, inv, cont, p, ncyc, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
